// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM states and divide-by-zero fill.
// Imported by restoring_divider and its helpers.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Quotient returned on divide-by-zero; slice to the operand width.
  localparam logic [63:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder, the cell of the ripple-carry chain.
// a_i/b_i/c_i in; s_o sum, c_o carry out.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/trial_subtractor.sv
// Combinational a - b as a + ~b + 1 on a full-adder ripple chain.
// a_i/b_i in; diff_o result, no_borrow_o carry out of the top cell.
module trial_subtractor #(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         no_borrow_o
);

  logic [W:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_fa
    full_adder u_fa (
      .a_i(a_i[i]),
      .b_i(~b_i[i]),
      .c_i(carry[i]),
      .s_o(diff_o[i]),
      .c_o(carry[i+1])
    );
  end

  assign no_borrow_o = carry[W];

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider, one trial subtraction per clock.
// start_i/dividend_i/divisor_i in; busy_o, done_o, quotient_o, remainder_o, flag_z_o out.
module restoring_divider
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             flag_z_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] qout_q, qout_d;
  logic [WIDTH-1:0] rout_q, rout_d;
  logic             flag_z_q, flag_z_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             no_borrow;

  assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};

  trial_subtractor #(
    .W(WIDTH + 1)
  ) u_sub (
    .a_i(shifted),
    .b_i({1'b0, div_q}),
    .diff_o(trial),
    .no_borrow_o(no_borrow)
  );

  // Partial remainder stays below the divisor, so its top bit is never read.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_q[WIDTH];

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    div_d    = div_q;
    qout_d   = qout_q;
    rout_d   = rout_q;
    flag_z_d = flag_z_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (divisor_i != '0) begin
            div_d    = divisor_i;
            quo_d    = dividend_i;
            rem_d    = '0;
            count_d  = CW'(WIDTH);
            flag_z_d = 1'b0;
            state_d  = CALC;
          end else begin
            qout_d   = DIV_ZERO_Q[WIDTH-1:0];
            rout_d   = dividend_i;
            flag_z_d = 1'b1;
            state_d  = DONE;
          end
        end
      end
      CALC: begin
        count_d = count_q - 1'b1;
        if (no_borrow) begin
          rem_d = trial;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted;
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        // Last step: publish results on the same edge.
        if (count_q == CW'(1)) begin
          state_d = DONE;
          qout_d  = quo_d;
          rout_d  = rem_d[WIDTH-1:0];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      count_q  <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      qout_q   <= '0;
      rout_q   <= '0;
      flag_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      qout_q   <= qout_d;
      rout_q   <= rout_d;
      flag_z_q <= flag_z_d;
    end
  end

  assign busy_o      = (state_q == CALC) || (state_q == DONE);
  assign done_o      = (state_q == DONE);
  assign quotient_o  = qout_q;
  assign remainder_o = rout_q;
  assign flag_z_o    = flag_z_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed self-checking bench for restoring_divider, WIDTH=8.
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_restoring_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quo;
  logic [7:0] rem;
  logic       fz;

  int ncmp = 0;
  int nfail = 0;

  restoring_divider #(
    .WIDTH(8)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .start_i(start),
    .dividend_i(dividend),
    .divisor_i(divisor),
    .busy_o(busy),
    .done_o(done),
    .quotient_o(quo),
    .remainder_o(rem),
    .flag_z_o(fz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for done_o.
  task automatic run_div(input string tag, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] eq,
                         input logic [7:0] er, input logic ez,
                         input int elat);
    int lat;
    int nbusy;
    bit got;
    @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(negedge clk);
    start = 1'b0;
    dividend = 8'($urandom);
    divisor = 8'($urandom);
    lat = 1;
    nbusy = 0;
    got = 1'b0;
    while (!got && lat <= 20) begin
      if (busy) nbusy++;
      if (done) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_busy"}, nbusy, elat);
    chk({tag, "_q"}, quo, eq);
    chk({tag, "_r"}, rem, er);
    chk({tag, "_z"}, fz, ez);
    @(negedge clk);
    chk({tag, "_idle"}, {busy, done}, 0);
  endtask

  initial begin
    int ndone;
    int t1;
    int t2;
    logic [7:0] cq;
    logic [7:0] cr;
    rst_n = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    #12;
    chk("rst_outs", {busy, done, quo, rem, fz}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_div("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9);
    run_div("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9);
    run_div("d5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 9);
    run_div("d200_200", 8'd200, 8'd200, 8'd1, 8'd0, 1'b0, 9);
    run_div("d0_5", 8'd0, 8'd5, 8'd0, 8'd0, 1'b0, 9);
    run_div("d255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 9);
    run_div("d1_255", 8'd1, 8'd255, 8'd0, 8'd1, 1'b0, 9);
    run_div("d255_16", 8'd255, 8'd16, 8'd15, 8'd15, 1'b0, 9);
    run_div("d77_0", 8'd77, 8'd0, 8'hFF, 8'd77, 1'b1, 1);
    run_div("d10_3", 8'd10, 8'd3, 8'd3, 8'd1, 1'b0, 9);

    // Start during CALC and operand churn must not disturb the result.
    @(negedge clk);
    start = 1'b1;
    dividend = 8'd100;
    divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    dividend = 8'd50;
    divisor = 8'd5;
    @(negedge clk);
    start = 1'b0;
    dividend = 8'd99;
    divisor = 8'd3;
    ndone = 0;
    cq = '0;
    cr = '0;
    for (int i = 0; i < 14; i++) begin
      if (done) begin
        ndone++;
        cq = quo;
        cr = rem;
      end
      @(negedge clk);
    end
    chk("ign_ndone", ndone, 1);
    chk("ign_q", cq, 8'd14);
    chk("ign_r", cr, 8'd2);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    start = 1'b1;
    dividend = 8'd100;
    divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_outs", {busy, done, quo, rem, fz}, 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("arst_ndone", ndone, 0);
    rst_n = 1'b1;
    run_div("d9_2", 8'd9, 8'd2, 8'd4, 8'd1, 1'b0, 9);

    // Held start gives one result every WIDTH+2 cycles.
    @(negedge clk);
    start = 1'b1;
    dividend = 8'd20;
    divisor = 8'd6;
    t1 = -1;
    t2 = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        if (t1 < 0) t1 = i;
        else if (t2 < 0) t2 = i;
      end
    end
    start = 1'b0;
    chk("held_period", t2 - t1, 10);
    for (int i = 0; i < 15; i++) @(negedge clk);
    chk("held_q", quo, 8'd3);
    chk("held_r", rem, 8'd2);
    chk("held_idle", {busy, done}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
